// File: rtl/roi_scan_ctrl_if.sv
// Host-side start/done transaction interface for roi_scan_ctrl.
// The crc member exists only when ROI_SCAN_CRC_EN is defined.
interface roi_scan_ctrl_if #(
    parameter int unsigned DIN_N  = 256,
    parameter int unsigned DOUT_N = 256
);
    logic              start;
    logic [DIN_N-1:0]  vec;
    logic              busy;
    logic              done;
    logic [DOUT_N-1:0] result;
`ifdef ROI_SCAN_CRC_EN
    logic [15:0]       crc;

    modport master (output start, vec, input busy, done, result, crc);
    modport slave  (input start, vec, output busy, done, result, crc);
`else
    modport master (output start, vec, input busy, done, result);
    modport slave  (input start, vec, output busy, done, result);
`endif
endinterface

// File: rtl/roi_scan_ctrl.sv
// Sequencer for the serial ROI harness: shift stimulus in, strobe load/capture, shift result out.
// Optional CRC-16-CCITT over the returned bits with ROI_SCAN_CRC_EN; the harness return bit is sdo.
module roi_scan_ctrl #(
    parameter int unsigned DIN_N      = 256,
    parameter int unsigned DOUT_N     = 256,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    roi_scan_ctrl_if.slave host,
    output logic           di,
    output logic           stb,
    input  logic           sdo
);
    localparam int unsigned MaxIo  = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
    localparam int unsigned MaxCnt = (MaxIo > SETTLE_CYC) ? MaxIo : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {
        StIdle, StShiftIn, StLoad, StSettle, StCapture, StShiftOut, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DIN_N-1:0]  sr_q, sr_d;
    logic [DOUT_N-1:0] result_q, result_d;
    logic              di_q, di_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sdo_q;
    logic              accept;
    logic              sample;
`ifdef ROI_SCAN_CRC_EN
    logic [15:0]       crc_q, crc_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        result_d = result_q;
        accept   = 1'b0;
        sample   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    accept   = 1'b1;
                    state_d  = StShiftIn;
                    cnt_d    = CntW'(DIN_N - 1);
                    sr_d     = host.vec;
                    result_d = '0;
                end
            end
            StShiftIn: begin
                sr_d = sr_q << 1;
                if (cnt_q == '0) state_d = StLoad;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StLoad: begin
                if (SETTLE_CYC == 0) begin
                    state_d = StCapture;
                end else begin
                    state_d = StSettle;
                    cnt_d   = CntW'(SETTLE_CYC - 1);
                end
            end
            StSettle: begin
                if (cnt_q == '0) state_d = StCapture;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StCapture: begin
                state_d = StShiftOut;
                cnt_d   = CntW'(DOUT_N);
            end
            StShiftOut: begin
                // sdo is registered on entry, so the first cycle here only fills sdo_q
                sample = (cnt_q != CntW'(DOUT_N));
                if (sample) result_d = {result_q[DOUT_N-2:0], sdo_q};
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so di/stb/busy/done are plain flops
        di_d   = 1'b0;
        if (state_d == StShiftIn) di_d = accept ? host.vec[DIN_N-1] : sr_q[DIN_N-2];
        stb_d  = (state_d == StLoad) || (state_d == StCapture);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

`ifdef ROI_SCAN_CRC_EN
    always_comb begin
        crc_d = crc_q;
        if (accept)      crc_d = 16'hFFFF;
        else if (sample) crc_d = crc_step(crc_q, sdo_q);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sr_q     <= '0;
            result_q <= '0;
            di_q     <= 1'b0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sdo_q    <= 1'b0;
`ifdef ROI_SCAN_CRC_EN
            crc_q    <= 16'hFFFF;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            di_q     <= di_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sdo_q    <= sdo;
`ifdef ROI_SCAN_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign di          = di_q;
    assign stb         = stb_q;
    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.result = result_q;
`ifdef ROI_SCAN_CRC_EN
    assign host.crc    = crc_q;
`endif

endmodule

// File: tb/tb_roi_scan_ctrl.sv
// Self-checking bench for roi_scan_ctrl against a harness model whose ROI is dout = ~din.
// A second instance runs with SETTLE_CYC = 0 to check adjacent strobes.
module tb_roi_scan_ctrl;
    localparam int unsigned N      = 256;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned LAT    = 2 * N + SETTLE + 4;
    localparam int unsigned LAT0   = 2 * N + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    roi_scan_ctrl_if #(.DIN_N(N), .DOUT_N(N)) host ();
    roi_scan_ctrl_if #(.DIN_N(N), .DOUT_N(N)) host0 ();
    logic di, stb, sdo, di0, stb0, sdo0;

    roi_scan_ctrl #(.DIN_N(N), .DOUT_N(N), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .host(host), .di(di), .stb(stb), .sdo(sdo)
    );
    roi_scan_ctrl #(.DIN_N(N), .DOUT_N(N), .SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .host(host0), .di(di0), .stb(stb0), .sdo(sdo0)
    );

    // Harness model: din_shr/dout_shr shift every clock, stb loads din and captures ~din
    logic [N-1:0] din_shr = '0, din_reg = '0, dout_shr = '0;
    logic [N-1:0] din_shr0 = '0, din_reg0 = '0, dout_shr0 = '0;
    always @(posedge clk) begin
        din_shr   <= {din_shr[N-2:0], di};
        dout_shr  <= stb ? ~din_reg : {dout_shr[N-2:0], 1'b0};
        if (stb) din_reg <= din_shr;
        din_shr0  <= {din_shr0[N-2:0], di0};
        dout_shr0 <= stb0 ? ~din_reg0 : {dout_shr0[N-2:0], 1'b0};
        if (stb0) din_reg0 <= din_shr0;
    end
    assign sdo  = dout_shr[N-1];
    assign sdo0 = dout_shr0[N-1];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [15:0] crc_ref(input logic [N-1:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = N - 1; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    typedef struct {
        int unsigned  cyc;
        logic [N-1:0] result;
        logic [15:0]  crc;
    } exp_t;
    exp_t sb[$];

    // Monitor: serial/strobe capture relative to base, and done popped against the scoreboard
    int unsigned  base = 0;
    logic [N-1:0] di_cap = '0;
    int unsigned  di_stray = 0;
    int unsigned  done_seen = 0;
    int unsigned  stb_offs[$];
    always @(negedge clk) begin
        automatic int unsigned off = cyc - base;
        automatic exp_t e;
        if (rst_n) begin
            if (stb) stb_offs.push_back(off);
            if (off >= 1 && off <= N) di_cap[N - off] = di;
            else if (di) di_stray++;
            if (host.done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check("spurious_done", N'(host.done), '0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", N'(cyc), N'(e.cyc));
                    check("result", host.result, e.result);
`ifdef ROI_SCAN_CRC_EN
                    check("crc_at_done", N'(host.crc), N'(e.crc));
`endif
                end
            end
        end
    end

    task automatic begin_scan(input logic [N-1:0] v, input logic [N-1:0] exp, input bit hold);
        @(negedge clk);
        host.start = 1'b1;
        host.vec   = v;
        base       = cyc;
        di_cap     = '0;
        di_stray   = 0;
        stb_offs.delete();
        sb.push_back('{cyc: cyc + LAT, result: exp, crc: crc_ref(exp)});
        @(negedge clk);
        check("busy_after_accept", N'(host.busy), N'(1));
        if (!hold) host.start = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", N'(sb.size()), '0);
        sb.delete();
    endtask

    task automatic check_shape(input logic [N-1:0] v);
        check("di_order", di_cap, v);
        check("di_stray", N'(di_stray), '0);
        check("stb_count", N'(stb_offs.size()), N'(2));
        if (stb_offs.size() == 2) begin
            check("stb_load_off", N'(stb_offs[0]), N'(N + 1));
            check("stb_capture_off", N'(stb_offs[1]), N'(N + SETTLE + 2));
        end
    endtask

    typedef struct {
        logic [N-1:0] vec;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tv[4];

    logic [N-1:0] va, vb;
    int unsigned  d0;

    initial begin
        host.start  = 1'b0;
        host.vec    = '0;
        host0.start = 1'b0;
        host0.vec   = '0;

        tv[0] = '{vec: N'(1), exp: {{(N-1){1'b1}}, 1'b0}};
        tv[1] = '{vec: {1'b1, {(N-2){1'b0}}, 1'b1}, exp: {1'b0, {(N-2){1'b1}}, 1'b0}};
        tv[2] = '{vec: '0, exp: {N{1'b1}}};
        tv[3] = '{vec: {8{32'hA5C3_0F96}}, exp: {8{32'h5A3C_F069}}};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", N'(host.busy), '0);
        check("rst_done", N'(host.done), '0);
        check("rst_stb_di", N'({stb, di}), '0);
        check("rst_result", host.result, '0);
`ifdef ROI_SCAN_CRC_EN
        check("rst_crc", N'(host.crc), N'(16'hFFFF));
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            begin_scan(tv[i].vec, tv[i].exp, 1'b0);
            wait_drain(LAT + 20);
            check_shape(tv[i].vec);
            @(negedge clk);
            check("busy_idle", N'(host.busy), '0);
        end

        // start held high through a scan, vec changed mid-scan
        va = {4{64'h0123_4567_89AB_CDEF}};
        vb = {4{64'hFEDC_BA98_7654_3210}};
        d0 = done_seen;
        begin_scan(va, ~va, 1'b1);
        while (cyc < base + 100) @(negedge clk);
        host.vec = vb;
        while (cyc < base + LAT + 1) @(negedge clk);
        check("hold_first_done", N'(sb.size()), '0);
        check_shape(va);
        base     = cyc;
        di_cap   = '0;
        di_stray = 0;
        stb_offs.delete();
        sb.push_back('{cyc: cyc + LAT, result: ~vb, crc: crc_ref(~vb)});
        @(negedge clk);
        host.start = 1'b0;
        wait_drain(LAT + 20);
        check_shape(vb);
        repeat (30) @(negedge clk);
        check("hold_done_count", N'(done_seen - d0), N'(2));

        // Reset during SHIFT_OUT, then a clean scan
        begin_scan(va, ~va, 1'b0);
        while (cyc < base + N + SETTLE + 4 + 100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", N'(host.busy), '0);
        check("midrst_stb_di", N'({stb, di}), '0);
        check("midrst_result", host.result, '0);
`ifdef ROI_SCAN_CRC_EN
        check("midrst_crc", N'(host.crc), N'(16'hFFFF));
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin_scan(vb, ~vb, 1'b0);
        wait_drain(LAT + 20);
        check_shape(vb);

        // SETTLE_CYC = 0 instance: strobes adjacent, shorter latency
        begin
            automatic int unsigned b0 = 0;
            automatic int unsigned s_offs[$];
            automatic int unsigned done_off = 0;
            automatic logic [N-1:0] res0 = '0;
            @(negedge clk);
            host0.start = 1'b1;
            host0.vec   = va;
            b0 = cyc;
            @(negedge clk);
            host0.start = 1'b0;
            for (int k = 0; k < int'(LAT0) + 10 && done_off == 0; k++) begin
                if (stb0) s_offs.push_back(cyc - b0);
                if (host0.done) begin
                    done_off = cyc - b0;
                    res0     = host0.result;
                end
                @(negedge clk);
            end
            check("s0_done_off", N'(done_off), N'(LAT0));
            check("s0_result", res0, ~va);
            check("s0_stb_count", N'(s_offs.size()), N'(2));
            if (s_offs.size() == 2) begin
                check("s0_stb_load", N'(s_offs[0]), N'(N + 1));
                check("s0_stb_capture", N'(s_offs[1]), N'(N + 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got time %0t, want finish earlier", $time);
        $fatal(1);
    end

endmodule
